// File: rtl/customized_ieee_to_fixed_seq_pkg.sv
// Shared definitions for the customized IEEE-to-fixed-point decoder.
// Holds the exponent field geometry, the exponent bias and the FSM state
// encoding used by the top-level sequencer.
package customized_ieee_to_fixed_seq_pkg;

    localparam int EXP_W    = 8;    // exponent field width
    localparam int EXP_BIAS = 127;  // exponent bias
    localparam int SEXP_W   = 9;    // width of the unbiased signed exponent k

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/customized_ieee_to_fixed_seq_classify.sv
// ieee_field_classify: purely combinational field splitter and classifier.
// Ports:
//   ieee_val   - {sign, exp[7:0], mantissa} input word
//   sign       - sign bit
//   mantissa   - raw mantissa field (hidden 1 not included)
//   is_zero    - result is zero (exp==0 flush, or value below 2^-fra_len)
//   is_ovf     - result saturates (exp==255, or k >= int_len)
//   shift_left - direction of the iterative shift (k >= 0)
//   shift_cnt  - |k|, number of 1-bit shifts needed
module ieee_field_classify
    import customized_ieee_to_fixed_seq_pkg::*;
#(
    parameter int montissa_len = 23,
    parameter int int_len      = 32,
    parameter int fra_len      = 32
) (
    input  logic [montissa_len+8:0] ieee_val,
    output logic                    sign,
    output logic [montissa_len-1:0] mantissa,
    output logic                    is_zero,
    output logic                    is_ovf,
    output logic                    shift_left,
    output logic [SEXP_W-1:0]       shift_cnt
);

    logic [EXP_W-1:0]         exp_f;
    logic signed [SEXP_W-1:0] k;
    int                       k_int;

    assign sign     = ieee_val[montissa_len+8];
    assign exp_f    = ieee_val[montissa_len+7 -: EXP_W];
    assign mantissa = ieee_val[montissa_len-1:0];

    // k = exp - bias in 9-bit two's complement; range -127..128.
    assign k     = $signed({1'b0, exp_f}) - $signed(SEXP_W'(EXP_BIAS));
    assign k_int = int'(k);

    always_comb begin
        is_ovf     = (exp_f == {EXP_W{1'b1}}) || (k_int >= int_len);
        // Overflow takes priority so exp==255 never reads as zero.
        is_zero    = !is_ovf && ((exp_f == '0) || (-k_int > fra_len));
        shift_left = !k[SEXP_W-1];
        shift_cnt  = k[SEXP_W-1] ? SEXP_W'(-k) : SEXP_W'(k);
    end

endmodule

// File: rtl/customized_ieee_to_fixed_seq.sv
// customized_ieee_to_fixed_seq: converts a customized IEEE-style float into
// sign-magnitude fixed point using one 1-bit shift per cycle.
// Ports:
//   clk, rst    - clock, asynchronous active-high reset
//   in_valid    - ieee_val is valid
//   in_ready    - block can accept an input (IDLE only)
//   ieee_val    - {sign, exp[7:0], mantissa}
//   out_valid   - result valid, held until out_ready
//   out_ready   - consumer accepts the result
//   o_integer   - integer magnitude
//   o_fraction  - fraction magnitude, LSB weight 2^-fra_len
//   o_sign      - sign copied from ieee_val
//   o_overflow  - saturation occurred
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid never drops before the transfer and the payload is held
// stable while valid is high and ready is low.
module customized_ieee_to_fixed_seq
    import customized_ieee_to_fixed_seq_pkg::*;
#(
    parameter int montissa_len = 23,
    parameter int int_len      = 32,
    parameter int fra_len      = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [montissa_len+8:0] ieee_val,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [int_len-1:0]      o_integer,
    output logic [fra_len-1:0]      o_fraction,
    output logic                    o_sign,
    output logic                    o_overflow
);

    localparam int AW = int_len + fra_len;

    if (fra_len < montissa_len) begin : g_bad_fra_len
        $error("fra_len must be >= montissa_len");
    end

    logic                    c_sign;
    logic [montissa_len-1:0] c_mant;
    logic                    c_zero;
    logic                    c_ovf;
    logic                    c_left;
    logic [SEXP_W-1:0]       c_cnt;

    ieee_field_classify #(
        .montissa_len(montissa_len),
        .int_len     (int_len),
        .fra_len     (fra_len)
    ) u_classify (
        .ieee_val  (ieee_val),
        .sign      (c_sign),
        .mantissa  (c_mant),
        .is_zero   (c_zero),
        .is_ovf    (c_ovf),
        .shift_left(c_left),
        .shift_cnt (c_cnt)
    );

    state_t            state;
    logic [AW-1:0]     acc;
    logic [SEXP_W-1:0] cnt;
    logic              dir_left;
    logic [AW-1:0]     load_val;

    // Place the hidden 1 at bit fra_len, i.e. the value 1.m exactly.
    assign load_val = AW'({1'b1, c_mant}) << (fra_len - montissa_len);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            acc        <= '0;
            cnt        <= '0;
            dir_left   <= 1'b0;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            o_sign     <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        o_sign   <= c_sign;
                        dir_left <= c_left;
                        in_ready <= 1'b0;
                        if (c_ovf) begin
                            acc        <= '1;
                            cnt        <= '0;
                            o_overflow <= 1'b1;
                            out_valid  <= 1'b1;
                            state      <= ST_DONE;
                        end else if (c_zero) begin
                            acc        <= '0;
                            cnt        <= '0;
                            o_overflow <= 1'b0;
                            out_valid  <= 1'b1;
                            state      <= ST_DONE;
                        end else begin
                            acc        <= load_val;
                            cnt        <= c_cnt;
                            o_overflow <= 1'b0;
                            if (c_cnt == '0) begin
                                out_valid <= 1'b1;
                                state     <= ST_DONE;
                            end else begin
                                state <= ST_SHIFT;
                            end
                        end
                    end
                end
                ST_SHIFT: begin
                    // Right shifts drop low bits: truncation toward zero.
                    acc <= dir_left ? (acc << 1) : (acc >> 1);
                    cnt <= cnt - 1'b1;
                    if (cnt == SEXP_W'(1)) begin
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_integer  = acc[AW-1:fra_len];
    assign o_fraction = acc[fra_len-1:0];

endmodule
